// File: rtl/cmsdk_ahb_param_reg_pkg.sv
// Shared definitions for the parametrised AHB-Lite register slave:
// FSM encoding, AHB field constants, ID register offsets and byte-strobe decode.
package cmsdk_ahb_param_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Byte offsets of the ID registers, which occupy the top two words of the window
    function automatic logic [31:0] id0_offset(input int aw);
        return (32'd1 << aw) - 32'd4;
    endfunction

    function automatic logic [31:0] id1_offset(input int aw);
        return (32'd1 << aw) - 32'd8;
    endfunction

    function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/cmsdk_ahb_param_reg_bank.sv
// Register array with byte-lane write enables and a read mux that also
// serves the two read-only identification words.
module cmsdk_ahb_param_reg_bank
    import cmsdk_ahb_param_reg_pkg::*;
#(
    parameter int ADDRWIDTH = 12,
    parameter int NUM_REGS  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDRWIDTH-3:0]   idx,
    input  logic [3:0]             wr_strobe,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             eco_rev,
    output logic [31:0]            rd_data
);

    localparam int IDXW = ADDRWIDTH - 2;
    localparam logic [IDXW-1:0] ID0_IDX = IDXW'(id0_offset(ADDRWIDTH) >> 2);
    localparam logic [IDXW-1:0] ID1_IDX = IDXW'(id1_offset(ADDRWIDTH) >> 2);

    logic [31:0] regs_r [NUM_REGS];
    logic [31:0] reg_mux_s;

    // Register storage: cleared on reset, strobed lanes written otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_strobe[b] && (idx == IDXW'(i))) begin
                        regs_r[i][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // AND-OR mux keeps out-of-range indices reading zero without array bounds issues
    always_comb begin
        reg_mux_s = 32'h0000_0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_mux_s = reg_mux_s | ({32{idx == IDXW'(i)}} & regs_r[i]);
        end
    end

    // Final read selection including the identification words
    always_comb begin
        rd_data = 32'h0000_0000;
        if (idx == ID0_IDX) begin
            rd_data = {28'h000_0000, eco_rev};
        end else if (idx == ID1_IDX) begin
            rd_data = 32'(NUM_REGS);
        end else begin
            rd_data = reg_mux_s;
        end
    end

endmodule

// File: rtl/cmsdk_ahb_param_reg_slave.sv
// AHB-Lite register slave: address capture, legality decode, wait-state and
// two-cycle ERROR sequencing around the register bank.
module cmsdk_ahb_param_reg_slave
    import cmsdk_ahb_param_reg_pkg::*;
#(
    parameter int ADDRWIDTH   = 12,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [3:0]           ECOREVNUM,
    input  logic                 HSELS,
    input  logic [ADDRWIDTH-1:0] HADDRS,
    input  logic [1:0]           HTRANSS,
    input  logic [2:0]           HSIZES,
    input  logic                 HWRITES,
    input  logic                 HREADYS,
    input  logic [31:0]          HWDATAS,
    output logic                 HREADYOUTS,
    output logic                 HRESPS,
    output logic [31:0]          HRDATAS
);

    localparam int IDXW = ADDRWIDTH - 2;
    localparam logic [IDXW-1:0] ID0_IDX    = IDXW'(id0_offset(ADDRWIDTH) >> 2);
    localparam logic [IDXW-1:0] ID1_IDX    = IDXW'(id1_offset(ADDRWIDTH) >> 2);
    localparam logic [IDXW-1:0] NUM_REGS_I = IDXW'(NUM_REGS);
    localparam logic [2:0]      WAIT_INIT  = 3'(WAIT_STATES);

    state_e            state_r, state_n;
    logic [2:0]        cnt_r, cnt_n;
    logic              dphase_r;
    logic              write_r;
    logic [IDXW-1:0]   idx_r;
    logic [3:0]        strobe_r;

    logic              hready_s;
    logic              accept_s;
    logic              illegal_s;
    logic [IDXW-1:0]   addr_idx_s;
    logic              hit_reg_s;
    logic              hit_id_s;
    logic              misalign_s;
    logic [3:0]        wr_strobe_s;
    logic [31:0]       bank_rdata_s;

    assign hready_s   = (state_r == ST_IDLE) || (state_r == ST_ERR2);
    assign accept_s   = HSELS && HREADYS && hready_s &&
                        ((HTRANSS == HTRANS_NONSEQ) || (HTRANSS == HTRANS_SEQ));
    assign addr_idx_s = HADDRS[ADDRWIDTH-1:2];

    // Address-phase legality decode
    always_comb begin
        hit_reg_s  = (addr_idx_s < NUM_REGS_I);
        hit_id_s   = (addr_idx_s == ID0_IDX) || (addr_idx_s == ID1_IDX);
        misalign_s = ((HSIZES == HSIZE_HALF) && HADDRS[0]) ||
                     ((HSIZES == HSIZE_WORD) && (HADDRS[1:0] != 2'b00));
        illegal_s  = !(hit_reg_s || hit_id_s) || (HWRITES && hit_id_s) ||
                     (HSIZES > HSIZE_WORD) || misalign_s;
    end

    // FSM and wait-counter state register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Next-state logic; ERR2 accepts a new transfer exactly as IDLE does
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (accept_s) begin
                    if (illegal_s) begin
                        state_n = ST_ERR1;
                    end else if (WAIT_INIT != 3'd0) begin
                        state_n = ST_WAIT;
                        cnt_n   = WAIT_INIT;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 3'd1) begin
                    state_n = ST_IDLE;
                    cnt_n   = 3'd0;
                end else begin
                    cnt_n   = cnt_r - 3'd1;
                end
            end
            ST_ERR1: begin
                state_n = ST_ERR2;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 3'd0;
            end
        endcase
    end

    // Data-phase capture; only legal transfers open a data phase here
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dphase_r <= 1'b0;
            write_r  <= 1'b0;
            idx_r    <= '0;
            strobe_r <= 4'b0000;
        end else if (hready_s) begin
            dphase_r <= accept_s && !illegal_s;
            write_r  <= accept_s && HWRITES;
            idx_r    <= addr_idx_s;
            strobe_r <= byte_strobe(HSIZES, HADDRS[1:0]);
        end
    end

    // Writes commit only in the completing cycle of a legal write
    always_comb begin
        if (dphase_r && write_r && (state_r == ST_IDLE)) begin
            wr_strobe_s = strobe_r;
        end else begin
            wr_strobe_s = 4'b0000;
        end
    end

    // Bus response derived from the FSM state
    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
        case (state_r)
            ST_IDLE: begin
                HREADYOUTS = 1'b1;
                HRESPS     = HRESP_OKAY;
            end
            ST_WAIT: begin
                HREADYOUTS = 1'b0;
                HRESPS     = HRESP_OKAY;
            end
            ST_ERR1: begin
                HREADYOUTS = 1'b0;
                HRESPS     = HRESP_ERROR;
            end
            ST_ERR2: begin
                HREADYOUTS = 1'b1;
                HRESPS     = HRESP_ERROR;
            end
            default: begin
                HREADYOUTS = 1'b1;
                HRESPS     = HRESP_OKAY;
            end
        endcase
    end

    // Read data is visible only during a legal read data phase
    always_comb begin
        if (dphase_r && !write_r) begin
            HRDATAS = bank_rdata_s;
        end else begin
            HRDATAS = 32'h0000_0000;
        end
    end

    cmsdk_ahb_param_reg_bank #(
        .ADDRWIDTH (ADDRWIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_bank (
        .clk       (HCLK),
        .rst       (HRESET),
        .idx       (idx_r),
        .wr_strobe (wr_strobe_s),
        .wr_data   (HWDATAS),
        .eco_rev   (ECOREVNUM),
        .rd_data   (bank_rdata_s)
    );

endmodule
